// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// clk and rst stay outside the bundle as plain ports.
interface div_unit_if #(
  parameter int W = 32
);
  logic           start;
  logic           signed_div;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           cancel;
  logic           busy;
  logic           ready;
  logic [2*W-1:0] result;

  modport master (
    output start, signed_div, a, b, cancel,
    input  busy, ready, result
  );

  modport slave (
    input  start, signed_div, a, b, cancel,
    output busy, ready, result
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: W shift-subtract steps, result = {remainder, quotient}.
// Signed operands are divided as magnitudes and the signs are applied on the final step.
module div_unit #(
  parameter int W = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave dif
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIVZERO = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;
  localparam int CW = $clog2(W) + 1;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   dsr_q, dsr_d;
  logic           negq_q, negq_d;
  logic           negr_q, negr_d;
  logic [2*W-1:0] result_q, result_d;

  logic [W:0]     shift_rem;
  logic [W:0]     trial;
  logic           fit;
  logic [W-1:0]   rem_step;
  logic [W-1:0]   quo_step;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;

  // One restoring step: dividend bits enter the partial remainder MSB first.
  assign shift_rem = {rem_q, quo_q[W-1]};
  assign trial     = shift_rem - {1'b0, dsr_q};
  assign fit       = ~trial[W];
  assign rem_step  = fit ? trial[W-1:0] : shift_rem[W-1:0];
  assign quo_step  = {quo_q[W-2:0], fit};

  assign mag_a = (dif.signed_div && dif.a[W-1]) ? -dif.a : dif.a;
  assign mag_b = (dif.signed_div && dif.b[W-1]) ? -dif.b : dif.b;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    if (dif.cancel) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dif.start) begin
            if (dif.b != '0) begin
              quo_d   = mag_a;
              rem_d   = '0;
              dsr_d   = mag_b;
              negq_d  = dif.signed_div && (dif.a[W-1] ^ dif.b[W-1]);
              negr_d  = dif.signed_div && dif.a[W-1];
              cnt_d   = '0;
              state_d = S_ON;
            end else begin
              // Raw dividend is parked in the quotient register for the remainder.
              quo_d   = dif.a;
              state_d = S_DIVZERO;
            end
          end
        end
        S_DIVZERO: begin
          result_d = {quo_q, {W{1'b1}}};
          state_d  = S_DONE;
        end
        S_ON: begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) begin
            result_d = {negr_q ? -rem_step : rem_step,
                        negq_q ? -quo_step : quo_step};
            state_d  = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign dif.busy   = (state_q == S_DIVZERO) || (state_q == S_ON);
  assign dif.ready  = (state_q == S_DONE);
  assign dif.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Randomized scoreboard bench for div_unit: stimulus pushes expected results, a monitor
// pops and compares them on every ready pulse.
module tb_div_unit;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   txn;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp;

  div_unit_if #(.W(W)) dif();
  div_unit #(.W(W)) dut (.clk(clk), .rst(rst), .dif(dif.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division; 64-bit signed arithmetic sidesteps INT_MIN/-1 overflow.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sq, sr;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sq = longint'($signed(a)) / longint'($signed(b));
      sr = longint'($signed(a)) % longint'($signed(b));
      return {sr[31:0], sq[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 20));
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && dif.ready) begin
      txn++;
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", 64'd1, 64'd0);
      end else begin
        last_exp = exp_q.pop_front();
        $display("txn %0d: result=%h expected=%h", txn, dif.result, last_exp);
        chk("result", dif.result, last_exp);
        chk("busy_in_done", 64'(dif.busy), 64'd0);
      end
    end
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input bit toggle);
    int nbusy;
    int cyc;
    @(negedge clk);
    dif.a = a; dif.b = b; dif.signed_div = s; dif.start = 1'b1;
    exp_q.push_back(ref_div(a, b, s));
    @(negedge clk);
    dif.start = 1'b0;
    nbusy = 0;
    cyc = 0;
    while (!dif.ready && cyc < 100) begin
      if (dif.busy) nbusy++;
      if (toggle) begin
        dif.a = $urandom; dif.b = $urandom; dif.signed_div = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) chk("ready_timeout", 64'(cyc), 64'd0);
    chk("busy_cycles", 64'(nbusy), (b == 32'd0) ? 64'd1 : 64'(W));
  endtask

  initial begin
    logic [63:0] prev;
    errors = 0; checks = 0; txn = 0;
    rst = 1'b1;
    dif.start = 1'b0; dif.signed_div = 1'b0; dif.a = '0; dif.b = '0; dif.cancel = 1'b0;
    #12;
    chk("reset_busy", 64'(dif.busy), 64'd0);
    chk("reset_ready", 64'(dif.ready), 64'd0);
    chk("reset_result", dif.result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div(32'd100, 32'd7, 1'b0, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    run_div(32'h0000_1234, 32'd0, 1'b0, 1'b0);
    run_div(32'd100, 32'd7, 1'b0, 1'b1);

    // Cancel during the 10th ON cycle: no ready, result keeps prior value.
    prev = dif.result;
    @(negedge clk);
    dif.a = 32'd100; dif.b = 32'd7; dif.signed_div = 1'b0; dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (9) @(negedge clk);
    dif.cancel = 1'b1;
    @(negedge clk);
    dif.cancel = 1'b0;
    chk("cancel_busy", 64'(dif.busy), 64'd0);
    chk("cancel_ready", 64'(dif.ready), 64'd0);
    chk("cancel_result", dif.result, prev);

    // Cancel and start together in IDLE: nothing launches.
    dif.start = 1'b1; dif.cancel = 1'b1; dif.b = 32'd3;
    @(negedge clk);
    dif.start = 1'b0; dif.cancel = 1'b0;
    chk("cancel_start_busy", 64'(dif.busy), 64'd0);
    run_div(32'd100, 32'd7, 1'b0, 1'b0);

    // Asynchronous reset mid-ON clears outputs without a clock edge.
    @(negedge clk);
    dif.a = 32'd55; dif.b = 32'd5; dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(dif.busy), 64'd0);
    chk("arst_ready", 64'(dif.ready), 64'd0);
    chk("arst_result", dif.result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      ra = pick_operand();
      rb = ($urandom_range(0, 9) == 0) ? 32'd0 : pick_operand();
      run_div(ra, rb, 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
